// File: rtl/rr_arb_4_onehot.sv
// Round-robin arbiter producing a registered one-hot grant, held until the consumer releases it.
// Define ARB_TIMEOUT_EN to force-release a grant after MAX_HOLD cycles with a one-cycle timeout pulse.
module rr_arb_4_onehot #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] grant,
  output logic            grant_v,
  output logic            timeout
);

  localparam int PTR_W = $clog2(NREQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] last, last_nxt;
  logic [PTR_W-1:0] gnt_idx, gnt_idx_nxt;
  logic [PTR_W-1:0] pick_idx;
  logic [NREQ-1:0]  grant_nxt;
  logic             found;
  logic             release_req;
  logic             force_rel;

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int offs);
    int s;
    s = (int'(base) + offs) % NREQ;
    return PTR_W'(s);
  endfunction

  // Search starts just past the last granted index and wraps, so every requester gets a turn.
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && req[wrap_idx(last, i)]) begin
        found    = 1'b1;
        pick_idx = wrap_idx(last, i);
      end
    end
  end

  assign release_req = (state == GRANT) && (done || !req[gnt_idx]);

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    last_nxt    = last;
    gnt_idx_nxt = gnt_idx;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt   = GRANT;
          grant_nxt   = NREQ'(1) << pick_idx;
          gnt_idx_nxt = pick_idx;
        end
      end
      GRANT: begin
        if (release_req || force_rel) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          last_nxt  = gnt_idx;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant   <= '0;
      grant_v <= 1'b0;
      last    <= PTR_W'(NREQ - 1);
      gnt_idx <= '0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      grant_v <= |grant_nxt;
      last    <= last_nxt;
      gnt_idx <= gnt_idx_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int HCW = $clog2(MAX_HOLD) + 1;

  logic [HCW-1:0] hold_cnt;

  // A normal release on the same edge takes priority, so no timeout pulse in that case.
  assign force_rel = (state == GRANT) && !release_req && (hold_cnt >= HCW'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= force_rel;
      if (state != GRANT) begin
        hold_cnt <= '0;
      end else if (hold_cnt != '1) begin
        hold_cnt <= hold_cnt + HCW'(1);
      end
    end
  end
`else
  assign force_rel = 1'b0;
  // Always zero without the hold counter; MAX_HOLD is referenced so the parameter stays live.
  assign timeout   = (MAX_HOLD < 0);
`endif

endmodule

// File: tb/tb_rr_arb_4_onehot.sv
// Self-checking bench for rr_arb_4_onehot: table-driven vectors through a scoreboard queue,
// plus hand-written timeout and asynchronous-reset sequences.
module tb_rr_arb_4_onehot;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] exp_grant;
    logic       exp_to;
  } vec_t;

  typedef struct {
    logic [3:0] grant;
    logic       gv;
    logic       to;
    string      name;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic       grant_v;
  logic       timeout;

  int   checks;
  int   failures;
  exp_t sb[$];
  vec_t vecs[22];

  rr_arb_4_onehot #(.NREQ(4), .MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .grant_v (grant_v),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  // Drive inputs now (caller sits at a negedge) and queue what the next rising edge must produce.
  task automatic applyStimulus(input logic [3:0] r, input logic d, input logic [3:0] eg,
                               input logic et, input string name);
    exp_t e;
    req  = r;
    done = d;
    e.grant = eg;
    e.gv    = |eg;
    e.to    = et;
    e.name  = name;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_empty actual=0 expected=1");
    end else begin
      e = sb.pop_front();
      checkValue({e.name, " grant"}, grant, e.grant);
      checkValue({e.name, " grant_v"}, {3'b0, grant_v}, {3'b0, e.gv});
      checkValue({e.name, " timeout"}, {3'b0, timeout}, {3'b0, e.to});
    end
    @(negedge clk);
  endtask

  // The encoder downstream breaks if more than one grant bit is ever set.
  always @(negedge clk) begin
    checks++;
    if (!$onehot0(grant)) begin
      failures++;
      $display("[TB] FAIL onehot0 actual=%b expected=at_most_one_bit", grant);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{4'b1111, 1'b0, 4'b0001, 1'b0};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0000, 1'b0};
    vecs[2]  = '{4'b1111, 1'b0, 4'b0010, 1'b0};
    vecs[3]  = '{4'b1111, 1'b1, 4'b0000, 1'b0};
    vecs[4]  = '{4'b1111, 1'b0, 4'b0100, 1'b0};
    vecs[5]  = '{4'b1111, 1'b1, 4'b0000, 1'b0};
    vecs[6]  = '{4'b1111, 1'b0, 4'b1000, 1'b0};
    vecs[7]  = '{4'b1111, 1'b1, 4'b0000, 1'b0};
    vecs[8]  = '{4'b1111, 1'b0, 4'b0001, 1'b0};
    vecs[9]  = '{4'b1111, 1'b1, 4'b0000, 1'b0};
    vecs[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0};
    vecs[11] = '{4'b0100, 1'b0, 4'b0100, 1'b0};
    vecs[12] = '{4'b0100, 1'b0, 4'b0100, 1'b0};
    vecs[13] = '{4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[14] = '{4'b0001, 1'b0, 4'b0001, 1'b0};
    vecs[15] = '{4'b0011, 1'b0, 4'b0001, 1'b0};
    vecs[16] = '{4'b0011, 1'b1, 4'b0000, 1'b0};
    vecs[17] = '{4'b0011, 1'b0, 4'b0010, 1'b0};
    vecs[18] = '{4'b0011, 1'b0, 4'b0010, 1'b0};
    vecs[19] = '{4'b0001, 1'b1, 4'b0000, 1'b0};
    vecs[20] = '{4'b0001, 1'b0, 4'b0001, 1'b0};
    vecs[21] = '{4'b0000, 1'b0, 4'b0000, 1'b0};

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    req      = 4'b1111;
    done     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkValue("reset grant", grant, 4'b0000);
    checkValue("reset grant_v", {3'b0, grant_v}, 4'b0000);
    checkValue("reset timeout", {3'b0, timeout}, 4'b0000);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].req, vecs[i].done, vecs[i].exp_grant, vecs[i].exp_to,
                    $sformatf("vec%0d", i));
      checkOutput();
    end

`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0001, 1'b0, 4'b0001, 1'b0, $sformatf("to_hold%0d", i));
      checkOutput();
    end
    applyStimulus(4'b0001, 1'b0, 4'b0000, 1'b1, "to_fire");
    checkOutput();
    applyStimulus(4'b0001, 1'b0, 4'b0001, 1'b0, "to_regrant");
    checkOutput();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0001, 1'b0, 4'b0001, 1'b0, $sformatf("to_rehold%0d", i));
      checkOutput();
    end
    applyStimulus(4'b0001, 1'b1, 4'b0000, 1'b0, "to_release_wins");
    checkOutput();
    applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, "to_idle");
    checkOutput();
`endif

    applyStimulus(4'b0100, 1'b0, 4'b0100, 1'b0, "pre_reset");
    checkOutput();
    #2;
    rst_n = 1'b0;
    #1;
    checkValue("async_reset grant", grant, 4'b0000);
    checkValue("async_reset grant_v", {3'b0, grant_v}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b1100, 1'b0, 4'b0100, 1'b0, "post_reset");
    checkOutput();
    applyStimulus(4'b1100, 1'b1, 4'b0000, 1'b0, "post_reset_rel");
    checkOutput();
    applyStimulus(4'b1100, 1'b0, 4'b1000, 1'b0, "post_reset_next");
    checkOutput();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
